// File: rtl/projectile_pool_if.sv
// Spawn port of the projectile pool: valid/ready handshake carrying the
// initial position, signed per-axis velocity and wall mode of a new projectile.
interface projectile_pool_if #(
    parameter int W  = 16,
    parameter int VW = 5
);
    logic                 valid;
    logic                 ready;
    logic [W-1:0]         x;
    logic [W-1:0]         y;
    logic signed [VW-1:0] vx;
    logic signed [VW-1:0] vy;
    logic                 mode;

    modport master (output valid, x, y, vx, vy, mode, input ready);
    modport slave  (input valid, x, y, vx, vy, mode, output ready);
endinterface

// File: rtl/projectile_pool.sv
// Pool of N projectiles moving inside the fighting box: spawn into the lowest
// free slot, advance once per animation strobe, pipelined hit check vs the heart.
module projectile_pool #(
    parameter int N        = 4,
    parameter int W        = 16,
    parameter int VW       = 5,
    parameter int FX       = 245,
    parameter int FY       = 230,
    parameter int F_WIDTH  = 150,
    parameter int F_HEIGHT = 150,
    parameter int R        = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ani_stb,
    input  logic             i_animate,
    input  logic             i_clear,
    projectile_pool_if.slave spawn,
    input  logic [W-1:0]     i_px,
    input  logic [W-1:0]     i_py,
    input  logic [W-1:0]     i_pr,
    output logic [N*W-1:0]   o_cx,
    output logic [N*W-1:0]   o_cy,
    output logic [W-1:0]     o_r,
    output logic [N-1:0]     o_active,
    output logic             o_hit,
    output logic [3:0]       o_hit_id
);
    // Two spare bits so pos + v never wraps and negative results stay visible.
    localparam int SW = W + 2;
    localparam logic signed [SW-1:0] X_BASE = SW'(FX);
    localparam logic signed [SW-1:0] Y_BASE = SW'(FY);
    localparam logic signed [SW-1:0] X_LO   = SW'(FX + R);
    localparam logic signed [SW-1:0] X_HI   = SW'(FX + F_WIDTH - R);
    localparam logic signed [SW-1:0] Y_LO   = SW'(FY + R);
    localparam logic signed [SW-1:0] Y_HI   = SW'(FY + F_HEIGHT - R);

    logic                 move;
    logic                 spawn_fire;
    logic [N-1:0]         load_sel;
    logic                 free_found;
    logic signed [SW-1:0] sx_sum, sy_sum;
    logic [W-1:0]         sx_clamp, sy_clamp;
    logic [W:0]           hit_lim;
    logic [N-1:0]         ovl;
    logic                 ovl_any;
    logic [3:0]           ovl_id;

    logic                 move_d_reg;
    logic                 pend_reg;
    logic [3:0]           pend_id_reg;
    logic                 hit_reg;
    logic [3:0]           hit_id_reg;

    assign move        = i_ani_stb & i_animate;
    assign spawn.ready = ~&o_active & ~i_clear;
    assign spawn_fire  = spawn.valid & spawn.ready;
    assign o_r         = W'(R);
    assign hit_lim     = {1'b0, i_pr} + (W+1)'(R);
    assign o_hit       = hit_reg;
    assign o_hit_id    = hit_id_reg;

    always_comb begin
        load_sel   = '0;
        free_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!o_active[k] && !free_found) begin
                load_sel[k] = 1'b1;
                free_found  = 1'b1;
            end
        end
    end

    always_comb begin
        sx_sum = X_BASE + $signed({2'b00, spawn.x});
        sy_sum = Y_BASE + $signed({2'b00, spawn.y});
        if (sx_sum < X_LO)      sx_clamp = X_LO[W-1:0];
        else if (sx_sum > X_HI) sx_clamp = X_HI[W-1:0];
        else                    sx_clamp = sx_sum[W-1:0];
        if (sy_sum < Y_LO)      sy_clamp = Y_LO[W-1:0];
        else if (sy_sum > Y_HI) sy_clamp = Y_HI[W-1:0];
        else                    sy_clamp = sy_sum[W-1:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            logic [W-1:0]         cx_reg, cy_reg;
            logic signed [VW-1:0] vx_reg, vy_reg;
            logic                 mode_reg, active_reg;
            logic signed [SW-1:0] nx, ny;
            logic                 x_lo, x_hi, y_lo, y_hi;
            logic [W-1:0]         dx, dy;

            assign nx   = $signed({2'b00, cx_reg}) + $signed({{(SW-VW){vx_reg[VW-1]}}, vx_reg});
            assign ny   = $signed({2'b00, cy_reg}) + $signed({{(SW-VW){vy_reg[VW-1]}}, vy_reg});
            assign x_lo = nx < X_LO;
            assign x_hi = nx > X_HI;
            assign y_lo = ny < Y_LO;
            assign y_hi = ny > Y_HI;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    active_reg <= 1'b0;
                    cx_reg     <= '0;
                    cy_reg     <= '0;
                    vx_reg     <= '0;
                    vy_reg     <= '0;
                    mode_reg   <= 1'b0;
                end else if (i_clear) begin
                    active_reg <= 1'b0;
                end else if (spawn_fire && load_sel[gi]) begin
                    active_reg <= 1'b1;
                    cx_reg     <= sx_clamp;
                    cy_reg     <= sy_clamp;
                    vx_reg     <= spawn.vx;
                    vy_reg     <= spawn.vy;
                    mode_reg   <= spawn.mode;
                end else if (move && active_reg) begin
                    if (mode_reg && (x_lo || x_hi || y_lo || y_hi)) begin
                        active_reg <= 1'b0;
                    end else begin
                        // Axes are independent, so a corner contact reflects both.
                        if (x_lo)      begin cx_reg <= X_LO[W-1:0]; vx_reg <= -vx_reg; end
                        else if (x_hi) begin cx_reg <= X_HI[W-1:0]; vx_reg <= -vx_reg; end
                        else                 cx_reg <= nx[W-1:0];
                        if (y_lo)      begin cy_reg <= Y_LO[W-1:0]; vy_reg <= -vy_reg; end
                        else if (y_hi) begin cy_reg <= Y_HI[W-1:0]; vy_reg <= -vy_reg; end
                        else                 cy_reg <= ny[W-1:0];
                    end
                end
            end

            assign dx       = (cx_reg >= i_px) ? cx_reg - i_px : i_px - cx_reg;
            assign dy       = (cy_reg >= i_py) ? cy_reg - i_py : i_py - cy_reg;
            assign ovl[gi]  = active_reg && ({1'b0, dx} <= hit_lim) && ({1'b0, dy} <= hit_lim);

            assign o_cx[gi*W +: W] = cx_reg;
            assign o_cy[gi*W +: W] = cy_reg;
            assign o_active[gi]    = active_reg;
        end
    endgenerate

    // Descending scan so the lowest overlapping index is the one that sticks.
    always_comb begin
        ovl_any = 1'b0;
        ovl_id  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (ovl[k]) begin
                ovl_any = 1'b1;
                ovl_id  = 4'(k);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            move_d_reg  <= 1'b0;
            pend_reg    <= 1'b0;
            pend_id_reg <= '0;
            hit_reg     <= 1'b0;
            hit_id_reg  <= '0;
        end else begin
            move_d_reg <= move;
            pend_reg   <= move_d_reg & ovl_any;
            if (move_d_reg && ovl_any) pend_id_reg <= ovl_id;
            hit_reg    <= pend_reg;
            if (pend_reg) hit_id_reg <= pend_id_reg;
        end
    end
endmodule

// File: tb/tb_projectile_pool.sv
// Bench for projectile_pool: directed vector table, hand-written corner sequences
// and randomized traffic, all checked against a behavioural model of the pool.
`timescale 1ns/1ps
module tb_projectile_pool;
    localparam int N = 4, W = 16, VW = 5;
    localparam int FX = 245, FY = 230, FW = 150, FH = 150, R = 5;
    localparam int XLO = FX + R, XHI = FX + FW - R, YLO = FY + R, YHI = FY + FH - R;

    logic           clk = 1'b0;
    logic           rst, stb, anim, clr;
    logic [W-1:0]   px, py, pr;
    logic [N*W-1:0] cx, cy;
    logic [W-1:0]   r;
    logic [N-1:0]   act;
    logic           hit;
    logic [3:0]     hit_id;

    projectile_pool_if #(.W(W), .VW(VW)) sp();

    projectile_pool #(.N(N), .W(W), .VW(VW), .FX(FX), .FY(FY), .F_WIDTH(FW), .F_HEIGHT(FH), .R(R)) dut (
        .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_animate(anim), .i_clear(clr),
        .spawn(sp), .i_px(px), .i_py(py), .i_pr(pr),
        .o_cx(cx), .o_cy(cy), .o_r(r), .o_active(act), .o_hit(hit), .o_hit_id(hit_id)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct { int due; int id; } hit_t;
    int   m_act[N], m_x[N], m_y[N], m_vx[N], m_vy[N], m_mode[N];
    int   m_hit, m_hit_id, cyc, last_spawn;
    hit_t hq[$];
    int   checks = 0, errors = 0;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_act[k] = 0; m_x[k] = 0; m_y[k] = 0; m_vx[k] = 0; m_vy[k] = 0; m_mode[k] = 0;
        end
        m_hit = 0; m_hit_id = 0;
        hq.delete();
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic void model_move(input int k);
        int nx, ny;
        nx = m_x[k] + m_vx[k];
        ny = m_y[k] + m_vy[k];
        if (m_mode[k] != 0 && (nx < XLO || nx > XHI || ny < YLO || ny > YHI)) begin
            m_act[k] = 0;
            return;
        end
        if (nx < XLO || nx > XHI) m_vx[k] = -m_vx[k];
        if (ny < YLO || ny > YHI) m_vy[k] = -m_vy[k];
        m_x[k] = clampi(nx, XLO, XHI);
        m_y[k] = clampi(ny, YLO, YHI);
    endfunction

    function automatic int model_ready();
        int any_free = 0;
        for (int k = 0; k < N; k++) if (m_act[k] == 0) any_free = 1;
        return (clr == 1'b1) ? 0 : any_free;
    endfunction

    function automatic void model_edge();
        int free_k, id, lim;
        bit mv, fire;
        mv     = stb && anim;
        free_k = -1;
        for (int k = N - 1; k >= 0; k--) if (m_act[k] == 0) free_k = k;
        fire       = sp.valid && (model_ready() != 0);
        last_spawn = -1;
        cyc++;
        if (rst) begin
            model_reset();
            return;
        end
        if (clr) begin
            for (int k = 0; k < N; k++) m_act[k] = 0;
        end else begin
            if (mv) for (int k = 0; k < N; k++) if (m_act[k] != 0) model_move(k);
            if (fire) begin
                m_act[free_k]  = 1;
                m_x[free_k]    = clampi(FX + int'(sp.x), XLO, XHI);
                m_y[free_k]    = clampi(FY + int'(sp.y), YLO, YHI);
                m_vx[free_k]   = int'($signed(sp.vx));
                m_vy[free_k]   = int'($signed(sp.vy));
                m_mode[free_k] = int'(sp.mode);
                last_spawn     = free_k;
            end
        end
        m_hit = 0;
        if (hq.size() > 0 && hq[0].due == cyc) begin
            m_hit    = 1;
            m_hit_id = hq[0].id;
            void'(hq.pop_front());
        end
        if (mv) begin
            id  = -1;
            lim = R + int'(pr);
            for (int k = N - 1; k >= 0; k--)
                if (m_act[k] != 0 && (m_x[k] - int'(px)) <= lim && (int'(px) - m_x[k]) <= lim &&
                    (m_y[k] - int'(py)) <= lim && (int'(py) - m_y[k]) <= lim) id = k;
            if (id >= 0) hq.push_back('{cyc + 2, id});
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        rst = 1'b0; stb = 1'b0; clr = 1'b0; sp.valid = 1'b0;
    endtask

    task automatic set_spawn(input int x, input int y, input int vx, input int vy, input int mode);
        sp.valid = 1'b1;
        sp.x     = W'(x);
        sp.y     = W'(y);
        sp.vx    = VW'(vx);
        sp.vy    = VW'(vy);
        sp.mode  = mode[0];
    endtask

    task automatic compare_all();
        int mask = 0;
        for (int k = 0; k < N; k++) mask |= (m_act[k] << k);
        chk("active", int'(act), mask);
        chk("hit", int'(hit), m_hit);
        chk("hit_id", int'(hit_id), m_hit_id);
        for (int k = 0; k < N; k++) begin
            if (m_act[k] != 0) begin
                chk($sformatf("cx[%0d]", k), int'(cx[k*W +: W]), m_x[k]);
                chk($sformatf("cy[%0d]", k), int'(cy[k*W +: W]), m_y[k]);
            end
        end
    endtask

    // One clock: check ready against the pending inputs, advance model and DUT, compare.
    task automatic step();
        #1;
        chk("spawn_ready", int'(sp.ready), model_ready());
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
        if (last_spawn >= 0)
            $display("spawn slot=%0d pos=(%0d,%0d) v=(%0d,%0d) mode=%0d", last_spawn,
                     m_x[last_spawn], m_y[last_spawn], m_vx[last_spawn], m_vy[last_spawn], m_mode[last_spawn]);
        idle();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst, stb, clr, sv;
        int sx, sy, svx, svy, smode;
        int e_act, e_cx0, e_cy0, e_rdy;
    } vec_t;
    vec_t tbl[18];

    initial begin
        tbl[0]  = '{1, 0, 0, 0,   0,   0,  0, 0, 0,   0,   0,   0, 1};
        tbl[1]  = '{0, 0, 0, 1,  10,  10,  3, 0, 0,   1, 255, 240, 1};
        tbl[2]  = '{0, 1, 0, 0,   0,   0,  0, 0, 0,   1, 258, 240, 1};
        tbl[3]  = '{0, 0, 1, 0,   0,   0,  0, 0, 0,   0, 258, 240, 1};
        tbl[4]  = '{0, 0, 0, 1, 143,  10,  4, 0, 0,   1, 388, 240, 1};
        tbl[5]  = '{0, 1, 0, 0,   0,   0,  0, 0, 0,   1, 390, 240, 1};
        tbl[6]  = '{0, 1, 0, 0,   0,   0,  0, 0, 0,   1, 386, 240, 1};
        tbl[7]  = '{0, 0, 1, 0,   0,   0,  0, 0, 0,   0, 386, 240, 1};
        tbl[8]  = '{0, 0, 0, 1, 143,  10,  4, 0, 1,   1, 388, 240, 1};
        tbl[9]  = '{0, 1, 0, 0,   0,   0,  0, 0, 0,   0,  -1,  -1, 1};
        tbl[10] = '{0, 0, 0, 1,   0, 200, -2, 1, 0,   1, 250, 375, 1};
        tbl[11] = '{0, 0, 0, 1,  50,  50,  0, 0, 0,   3, 250, 375, 1};
        tbl[12] = '{0, 0, 0, 1,  60,  60,  0, 0, 0,   7, 250, 375, 1};
        tbl[13] = '{0, 0, 0, 1,  70,  70,  0, 0, 0,  15, 250, 375, 0};
        tbl[14] = '{0, 0, 0, 1,  80,  80,  0, 0, 0,  15, 250, 375, 0};
        tbl[15] = '{0, 1, 0, 0,   0,   0,  0, 0, 0,  15, 250, 375, 0};
        tbl[16] = '{0, 1, 0, 0,   0,   0,  0, 0, 0,  15, 252, 374, 0};
        tbl[17] = '{0, 0, 1, 0,   0,   0,  0, 0, 0,   0, 252, 374, 1};
    end

    initial begin
        idle();
        anim = 1'b1; px = '0; py = '0; pr = '0;
        sp.x = '0; sp.y = '0; sp.vx = '0; sp.vy = '0; sp.mode = 1'b0;
        cyc = 0; last_spawn = -1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("radius", int'(r), R);

        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst; stb = tbl[i].stb; clr = tbl[i].clr;
            if (tbl[i].sv) set_spawn(tbl[i].sx, tbl[i].sy, tbl[i].svx, tbl[i].svy, tbl[i].smode);
            step();
            #1;
            chk($sformatf("tbl%0d active", i), int'(act), tbl[i].e_act);
            if (tbl[i].e_cx0 >= 0) chk($sformatf("tbl%0d cx0", i), int'(cx[W-1:0]), tbl[i].e_cx0);
            if (tbl[i].e_cy0 >= 0) chk($sformatf("tbl%0d cy0", i), int'(cy[W-1:0]), tbl[i].e_cy0);
            chk($sformatf("tbl%0d ready", i), int'(sp.ready), tbl[i].e_rdy);
        end

        // Hit timing and lowest-id reporting, then the |d| = R+pr boundary.
        rst = 1'b1; step();
        px = 16'd300; py = 16'd300; pr = 16'd4;
        set_spawn(5, 5, 0, 0, 0);   step();
        set_spawn(55, 70, 0, 0, 0); step();
        stb = 1'b1; step(); chk("seqA hit E", int'(hit), 0);
        step();               chk("seqA hit E+1", int'(hit), 0);
        step();               chk("seqA hit E+2", int'(hit), 1);
                              chk("seqA id E+2", int'(hit_id), 1);
        step();               chk("seqA hit E+3", int'(hit), 0);
                              chk("seqA id held", int'(hit_id), 1);
        px = 16'd310; stb = 1'b1; step(); step(); step();
        chk("seqA dx=10 no hit", int'(hit), 0);
        px = 16'd309; stb = 1'b1; step(); step(); step();
        chk("seqA dx=9 hit", int'(hit), 1);
        step();

        // Spawn coinciding with a move, then reset while a hit is in flight.
        rst = 1'b1; step();
        px = 16'd258; py = 16'd240; pr = 16'd2;
        set_spawn(10, 10, 3, 0, 0); step();
        stb = 1'b1; set_spawn(20, 20, 5, 5, 0); step();
        chk("seqB moved cx0", int'(cx[W-1:0]), 258);
        chk("seqB new cx1", int'(cx[W +: W]), 265);
        chk("seqB new cy1", int'(cy[W +: W]), 250);
        rst = 1'b1; step();
        chk("seqB rst active", int'(act), 0);
        step(); chk("seqB no hit 1", int'(hit), 0);
        step(); chk("seqB no hit 2", int'(hit), 0);

        // Clear beats a same-cycle spawn.
        set_spawn(30, 30, 1, 1, 0); step();
        clr = 1'b1; set_spawn(40, 40, 1, 1, 0);
        #1; chk("seqC ready in clear", int'(sp.ready), 0);
        step();
        chk("seqC clear active", int'(act), 0);

        // Randomized traffic.
        rst = 1'b1; step();
        px = 16'd320; py = 16'd305; pr = 16'd10;
        for (int i = 0; i < 2500; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            clr  = ($urandom_range(0, 39) == 0);
            stb  = ($urandom_range(0, 3) == 0);
            anim = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0)
                set_spawn(int'($urandom_range(0, 200)), int'($urandom_range(0, 200)),
                          int'($urandom_range(0, 30)) - 15, int'($urandom_range(0, 30)) - 15,
                          int'($urandom_range(0, 1)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
